// File: rtl/csr_stream_bridge_if.sv
// ---------------------------------------------------------------------------
// csr_stream_bridge_if
//   Bundles the Avalon-MM CSR slave port, the block stream towards the crypto
//   core and the result stream coming back from it.
//
//   Avalon-MM  : slave_address, slave_writedata, slave_write, slave_read,
//                slave_chipselect (bus -> bridge), slave_readdata (bridge -> bus)
//   To core    : core_data, core_valid (bridge -> core), core_ready (core -> bridge)
//   From core  : res_data, res_valid (core -> bridge), res_ready (bridge -> core)
//
//   modport slave  : the bridge's view
//   modport master : the system / core side (used by the testbench)
// ---------------------------------------------------------------------------
interface csr_stream_bridge_if #(
  parameter int SLAVE_ADDRESSWIDTH = 8,
  parameter int DATAWIDTH          = 32,
  parameter int WORDS              = 2
);
  localparam int BLKW = WORDS * DATAWIDTH;

  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address;
  logic [DATAWIDTH-1:0]          slave_writedata;
  logic                          slave_write;
  logic                          slave_read;
  logic                          slave_chipselect;
  logic [DATAWIDTH-1:0]          slave_readdata;

  logic [BLKW-1:0]               core_data;
  logic                          core_valid;
  logic                          core_ready;

  logic [BLKW-1:0]               res_data;
  logic                          res_valid;
  logic                          res_ready;

  modport slave (
    input  slave_address, slave_writedata, slave_write, slave_read, slave_chipselect,
    output slave_readdata,
    output core_data, core_valid,
    input  core_ready,
    input  res_data, res_valid,
    output res_ready
  );

  modport master (
    output slave_address, slave_writedata, slave_write, slave_read, slave_chipselect,
    input  slave_readdata,
    input  core_data, core_valid,
    output core_ready,
    output res_data, res_valid,
    input  res_ready
  );
endinterface

// File: rtl/csr_stream_bridge.sv
// ---------------------------------------------------------------------------
// csr_stream_bridge
//   Avalon-MM slave that stages multi-word blocks written by software into an
//   input ring buffer feeding a streaming crypto core, and collects result
//   blocks from the core into an output ring buffer that software pops.
//
//   Ports
//     clk      : clock
//     reset_n  : synchronous active-low reset
//     bus      : csr_stream_bridge_if.slave (CSR bus, core stream, result stream)
//     irq      : registered threshold interrupt on the output buffer fill level
//
//   CSR map (word addresses)
//     0  CTRL       b0 PUSH, b1 POP, b3 FLUSH (self-clearing), b2 RUN, b4 IRQ_EN
//     1  STATUS     b0 in_empty b1 in_full b2 out_empty b3 out_full
//                   b4 OVF b5 UNF (write 1 to clear) b6 RD_VALID
//     2  IN_COUNT   3 OUT_COUNT   4 IRQ_THRESH
//     8..8+WORDS-1  IN_STAGE (R/W)   16..16+WORDS-1 OUT_HOLD (RO), word 0 = LSBs
// ---------------------------------------------------------------------------
module csr_stream_bridge #(
  parameter int SLAVE_ADDRESSWIDTH = 8,
  parameter int DATAWIDTH          = 32,
  parameter int WORDS              = 2,
  parameter int DEPTH              = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  csr_stream_bridge_if.slave      bus,
  output logic                    irq
);

  localparam int BLKW = WORDS * DATAWIDTH;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef logic [SLAVE_ADDRESSWIDTH-1:0] addr_t;
  typedef logic [PTRW-1:0]               ptr_t;
  typedef logic [CNTW-1:0]               cnt_t;

  localparam addr_t ADDR_CTRL   = addr_t'(0);
  localparam addr_t ADDR_STATUS = addr_t'(1);
  localparam addr_t ADDR_INCNT  = addr_t'(2);
  localparam addr_t ADDR_OUTCNT = addr_t'(3);
  localparam addr_t ADDR_THRESH = addr_t'(4);
  localparam addr_t ADDR_STAGE  = addr_t'(8);
  localparam addr_t ADDR_HOLD   = addr_t'(16);

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_FETCH,
    FEED_PRESENT
  } feed_state_e;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic wr_en, rd_en;
  logic ctrl_wr, status_wr, thresh_wr;
  logic flush;

  assign wr_en     = bus.slave_chipselect && bus.slave_write;
  // A simultaneous write wins; the read is dropped and readdata holds.
  assign rd_en     = bus.slave_chipselect && bus.slave_read && !bus.slave_write;
  assign ctrl_wr   = wr_en && (bus.slave_address == ADDR_CTRL);
  assign status_wr = wr_en && (bus.slave_address == ADDR_STATUS);
  assign thresh_wr = wr_en && (bus.slave_address == ADDR_THRESH);
  // FLUSH acts in the write cycle itself so the core sees valid drop next cycle.
  assign flush     = ctrl_wr && bus.slave_writedata[3];

  // -------------------------------------------------------------------------
  // Control registers and staging words
  // -------------------------------------------------------------------------
  logic                 run, irq_en;
  cnt_t                 irq_thresh;
  logic                 push_pend, pop_pend;
  logic [DATAWIDTH-1:0] in_stage [WORDS];
  logic [BLKW-1:0]      stage_blk;

  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values of each other, matching real flops.
    if (!reset_n) begin
      run        <= 1'b0;
      irq_en     <= 1'b0;
      irq_thresh <= '0;
      push_pend  <= 1'b0;
      pop_pend   <= 1'b0;
      for (int w = 0; w < WORDS; w++) in_stage[w] <= '0;
    end else begin
      // PUSH/POP are registered so the buffer operation happens the cycle
      // after the CTRL write; they are dropped if FLUSH is in the same word.
      push_pend <= ctrl_wr && bus.slave_writedata[0] && !bus.slave_writedata[3];
      pop_pend  <= ctrl_wr && bus.slave_writedata[1] && !bus.slave_writedata[3];
      if (ctrl_wr) begin
        run    <= bus.slave_writedata[2];
        irq_en <= bus.slave_writedata[4];
      end
      if (thresh_wr) irq_thresh <= bus.slave_writedata[CNTW-1:0];
      for (int w = 0; w < WORDS; w++) begin
        if (wr_en && bus.slave_address == ADDR_STAGE + addr_t'(w))
          in_stage[w] <= bus.slave_writedata;
      end
    end
  end

  always_comb begin
    // NOTE: assigning a default before any conditional path keeps
    // combinational blocks from inferring latches.
    stage_blk = '0;
    for (int w = 0; w < WORDS; w++)
      stage_blk[w*DATAWIDTH +: DATAWIDTH] = in_stage[w];
  end

  function automatic cnt_t next_count(input cnt_t cnt, input logic inc, input logic dec);
    cnt_t res;
    res = cnt;
    if (inc && !dec)      res = cnt + 1'b1;
    else if (dec && !inc) res = cnt - 1'b1;
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Input ring buffer
  // -------------------------------------------------------------------------
  logic [BLKW-1:0] in_mem [DEPTH];
  logic [BLKW-1:0] in_rd_q;
  ptr_t            in_wr_ptr, in_rd_ptr;
  cnt_t            in_count;
  logic            in_full, in_empty;
  logic            push_go, fetch_go;

  assign in_full  = (in_count == CNT_FULL);
  assign in_empty = (in_count == '0);
  assign push_go  = push_pend && !in_full;

  // NOTE: the buffer RAMs carry no reset; their contents are only meaningful
  // between the pointers, which are reset, so this maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (push_go)  in_mem[in_wr_ptr] <= stage_blk;
    if (fetch_go) in_rd_q <= in_mem[in_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (push_go)  in_wr_ptr <= in_wr_ptr + 1'b1;
      if (fetch_go) in_rd_ptr <= in_rd_ptr + 1'b1;
      in_count <= next_count(in_count, push_go, fetch_go);
    end
  end

  // -------------------------------------------------------------------------
  // Feed FSM: IDLE issues the RAM read, FETCH captures it into core_data,
  // PRESENT holds until the core accepts.
  // -------------------------------------------------------------------------
  feed_state_e     state_q, state_d;
  logic            load_core, release_core;
  logic [BLKW-1:0] core_data_q;
  logic            core_valid_q;

  always_comb begin
    state_d      = state_q;
    fetch_go     = 1'b0;
    load_core    = 1'b0;
    release_core = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (run && !in_empty) begin
          fetch_go = 1'b1;
          state_d  = FEED_FETCH;
        end
      end
      FEED_FETCH: begin
        load_core = 1'b1;
        state_d   = FEED_PRESENT;
      end
      FEED_PRESENT: begin
        if (bus.core_ready) begin
          release_core = 1'b1;
          state_d      = FEED_IDLE;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= FEED_IDLE;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
    end else if (flush) begin
      // A presented block is dropped; core_data keeps its stale value.
      state_q      <= FEED_IDLE;
      core_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_core) begin
        core_data_q  <= in_rd_q;
        core_valid_q <= 1'b1;
      end else if (release_core) begin
        core_valid_q <= 1'b0;
      end
    end
  end

  assign bus.core_data  = core_data_q;
  assign bus.core_valid = core_valid_q;

  // -------------------------------------------------------------------------
  // Output ring buffer and OUT_HOLD
  // -------------------------------------------------------------------------
  logic [BLKW-1:0] out_mem [DEPTH];
  logic [BLKW-1:0] out_rd_q;
  logic [BLKW-1:0] out_hold;
  ptr_t            out_wr_ptr, out_rd_ptr;
  cnt_t            out_count;
  logic            out_full, out_empty;
  logic            res_go, pop_go, pop_load;
  logic            rd_valid;

  assign out_full      = (out_count == CNT_FULL);
  assign out_empty     = (out_count == '0);
  assign bus.res_ready = !out_full;
  assign res_go        = bus.res_valid && !out_full;
  assign pop_go        = pop_pend && !out_empty;

  always_ff @(posedge clk) begin
    if (res_go) out_mem[out_wr_ptr] <= bus.res_data;
    if (pop_go) out_rd_q <= out_mem[out_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
      pop_load   <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (res_go) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (pop_go) out_rd_ptr <= out_rd_ptr + 1'b1;
      out_count <= next_count(out_count, res_go, pop_go);
      // RAM read lands one cycle after the pop; RD_VALID follows OUT_HOLD.
      pop_load  <= pop_go;
      if (pop_go)        rd_valid <= 1'b0;
      else if (pop_load) rd_valid <= 1'b1;
    end
  end

  // OUT_HOLD is CSR state that survives FLUSH; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset_n)      out_hold <= '0;
    else if (pop_load) out_hold <= out_rd_q;
  end

  // -------------------------------------------------------------------------
  // Sticky error flags: a new event in the same cycle as a clear wins.
  // -------------------------------------------------------------------------
  logic ovf, unf;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (push_pend && in_full)   || (ovf && !(status_wr && bus.slave_writedata[4]));
      unf <= (pop_pend  && out_empty) || (unf && !(status_wr && bus.slave_writedata[5]));
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt: compares the registered count, hence one cycle of lag.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_en && (irq_thresh != '0) && (out_count >= irq_thresh);
  end

  // -------------------------------------------------------------------------
  // CSR read path
  // -------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] rd_mux;
  logic [DATAWIDTH-1:0] readdata_q;

  always_comb begin
    rd_mux = '0;
    if (bus.slave_address == ADDR_CTRL) begin
      rd_mux[2] = run;
      rd_mux[4] = irq_en;
    end else if (bus.slave_address == ADDR_STATUS) begin
      rd_mux[6:0] = {rd_valid, unf, ovf, out_full, out_empty, in_full, in_empty};
    end else if (bus.slave_address == ADDR_INCNT) begin
      rd_mux[CNTW-1:0] = in_count;
    end else if (bus.slave_address == ADDR_OUTCNT) begin
      rd_mux[CNTW-1:0] = out_count;
    end else if (bus.slave_address == ADDR_THRESH) begin
      rd_mux[CNTW-1:0] = irq_thresh;
    end
    for (int w = 0; w < WORDS; w++) begin
      if (bus.slave_address == ADDR_STAGE + addr_t'(w)) rd_mux = in_stage[w];
      if (bus.slave_address == ADDR_HOLD + addr_t'(w))  rd_mux = out_hold[w*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)   readdata_q <= '0;
    else if (rd_en) readdata_q <= rd_mux;
  end

  assign bus.slave_readdata = readdata_q;

endmodule

// File: tb/tb_csr_stream_bridge.sv
// ---------------------------------------------------------------------------
// tb_csr_stream_bridge
//   Self-checking bench for csr_stream_bridge (WORDS=2, DEPTH=4). A queue
//   based model of both ring buffers and the CSR flags predicts every value.
// ---------------------------------------------------------------------------
module tb_csr_stream_bridge;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int WORDS = 2;
  localparam int DEPTH = 4;
  localparam int BLKW  = WORDS * DW;

  localparam logic [AW-1:0] A_CTRL = 8'd0, A_STATUS = 8'd1, A_INCNT = 8'd2,
                            A_OUTCNT = 8'd3, A_THRESH = 8'd4, A_STAGE = 8'd8,
                            A_HOLD = 8'd16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  csr_stream_bridge_if #(.SLAVE_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .WORDS(WORDS)) bus ();

  csr_stream_bridge #(
    .SLAVE_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .WORDS(WORDS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [BLKW-1:0] in_q[$];
  logic [BLKW-1:0] out_q[$];
  logic [BLKW-1:0] hold_m;
  bit ovf_m, unf_m, rdv_m, run_m, irq_en_m;
  int thresh_m;

  // Core-side monitor: a handshake completes on the posedge after a negedge
  // at which valid && ready are seen (inputs only change just after posedge).
  logic [BLKW-1:0] got_q[$];
  int got_cyc[$];
  int cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.core_valid === 1'b1 && bus.core_ready === 1'b1) begin
      got_q.push_back(bus.core_data);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] exp_status();
    return {25'd0, rdv_m, unf_m, ovf_m, out_q.size() == DEPTH, out_q.size() == 0,
            in_q.size() == DEPTH, in_q.size() == 0};
  endfunction

  function automatic logic [DW-1:0] ctrl_word(input bit push, input bit pop, input bit flush);
    return {27'd0, irq_en_m, flush, run_m, pop, push};
  endfunction

  function automatic bit irq_cond(input int n);
    return irq_en_m && thresh_m != 0 && n >= thresh_m;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.slave_address = a; bus.slave_writedata = d;
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    @(posedge clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.slave_address = a;
    bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1;
    @(posedge clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_read = 1'b0;
    d = bus.slave_readdata;
  endtask

  task automatic push_block(input logic [BLKW-1:0] blk);
    csr_write(A_STAGE, blk[DW-1:0]);
    csr_write(A_STAGE + 8'd1, blk[BLKW-1:DW]);
    csr_write(A_CTRL, ctrl_word(1'b1, 1'b0, 1'b0));
    idle(1);
    if (in_q.size() < DEPTH) in_q.push_back(blk);
    else ovf_m = 1'b1;
  endtask

  task automatic pop_block();
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b1, 1'b0));
    idle(2);
    if (out_q.size() > 0) begin hold_m = out_q.pop_front(); rdv_m = 1'b1; end
    else unf_m = 1'b1;
  endtask

  task automatic drive_result(input logic [BLKW-1:0] blk);
    bit rdy_exp;
    rdy_exp = out_q.size() < DEPTH;
    bus.res_data = blk; bus.res_valid = 1'b1;
    checks++;
    if (bus.res_ready !== rdy_exp) begin
      errors++; $display("FAIL res_ready_before_result: got %b exp %b", bus.res_ready, rdy_exp);
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    if (rdy_exp) out_q.push_back(blk);
  endtask

  task automatic read_hold(output logic [BLKW-1:0] blk);
    logic [DW-1:0] lo, hi;
    csr_read(A_HOLD, lo);
    csr_read(A_HOLD + 8'd1, hi);
    blk = {hi, lo};
  endtask

  task automatic check_status(input string tag);
    logic [DW-1:0] d;
    csr_read(A_STATUS, d);
    checks++;
    if (d !== exp_status()) begin
      errors++; $display("FAIL status_%s: got %h exp %h", tag, d, exp_status());
    end
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin idle(1); k++; end
    checks++;
    if (got_q.size() < n) begin
      errors++; $display("FAIL timeout_%s: got %0d blocks exp %0d", tag, got_q.size(), n);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [DW-1:0] d;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    in_q.delete(); out_q.delete();
    ovf_m = 0; unf_m = 0; rdv_m = 0; run_m = 0; irq_en_m = 0; thresh_m = 0; hold_m = '0;
    checks++;
    if (bus.slave_readdata !== '0) begin errors++; $display("FAIL reset_readdata: got %h exp 0", bus.slave_readdata); end
    checks++;
    if (bus.core_valid !== 1'b0 || bus.core_data !== '0) begin
      errors++; $display("FAIL reset_core: valid %b data %h exp 0/0", bus.core_valid, bus.core_data);
    end
    checks++;
    if (bus.res_ready !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_ready_irq: res_ready %b irq %b exp 1/0", bus.res_ready, irq);
    end
    csr_read(A_STATUS, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL reset_status: got %h exp 5", d); end
    csr_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 0", d); end
  endtask

  task automatic test_single_block();
    logic [DW-1:0] d;
    logic [BLKW-1:0] exp;
    exp = 64'h2222222211111111;
    push_block(exp);
    csr_read(A_INCNT, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL single_incount_after_push: got %0d exp 1", d); end
    got_q.delete(); got_cyc.delete();
    bus.core_ready = 1'b1;
    run_m = 1'b1;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    wait_got(1, 20, "single");
    idle(6);
    void'(in_q.pop_front());
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d exp 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== exp) begin errors++; $display("FAIL single_data: got %h exp %h", got_q[0], exp); end
    end
    csr_read(A_INCNT, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL single_incount_end: got %0d exp 0", d); end
    run_m = 1'b0;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_overflow_wrap();
    logic [DW-1:0] d;
    logic [BLKW-1:0] exp_q[$];
    for (int i = 0; i < 5; i++) push_block({$urandom, $urandom});
    csr_read(A_INCNT, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL ovf_incount: got %0d exp 4", d); end
    check_status("ovf_set");
    csr_write(A_STATUS, 32'h10);
    ovf_m = 1'b0;
    check_status("ovf_clear");
    exp_q = in_q;
    got_q.delete(); got_cyc.delete();
    bus.core_ready = 1'b1;
    run_m = 1'b1;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    wait_got(4, 60, "drain");
    in_q.delete();
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_order[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < 4 && i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] - got_cyc[i-1] != 3) begin
        errors++; $display("FAIL back_to_back_gap[%0d]: got %0d cycles exp 3", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
    run_m = 1'b0;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    check_status("drained");
  endtask

  task automatic test_stall_flush();
    logic [DW-1:0] d;
    logic [BLKW-1:0] presented;
    int k;
    bus.core_ready = 1'b0;
    run_m = 1'b1;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    push_block({$urandom, $urandom});
    push_block({$urandom, $urandom});
    k = 0;
    while (bus.core_valid !== 1'b1 && k < 20) begin idle(1); k++; end
    presented = in_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.core_valid !== 1'b1 || bus.core_data !== presented) begin
        errors++; $display("FAIL stall_hold[%0d]: valid %b data %h exp 1/%h", i, bus.core_valid, bus.core_data, presented);
      end
    end
    @(posedge clk); #1;
    csr_read(A_INCNT, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL stall_incount: got %0d exp 1", d); end
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b1));
    in_q.delete(); out_q.delete(); ovf_m = 0; unf_m = 0; rdv_m = 0;
    checks++;
    if (bus.core_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", bus.core_valid); end
    csr_read(A_INCNT, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL flush_incount: got %0d exp 0", d); end
    csr_read(A_CTRL, d);
    checks++;
    if (d !== ctrl_word(1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL flush_ctrl_kept: got %h exp %h", d, ctrl_word(1'b0, 1'b0, 1'b0));
    end
    idle(4);
    checks++;
    if (bus.core_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_idle: got %b exp 0", bus.core_valid); end
    run_m = 1'b0;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    check_status("flushed");
  endtask

  task automatic test_results_irq();
    logic [DW-1:0] d;
    logic [BLKW-1:0] h;
    int prev;
    thresh_m = 3;
    csr_write(A_THRESH, 32'd3);
    irq_en_m = 1'b1;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      prev = out_q.size();
      drive_result({$urandom, $urandom});
      checks++;
      if (irq !== irq_cond(prev)) begin errors++; $display("FAIL irq_lag[%0d]: got %b exp %b", i, irq, irq_cond(prev)); end
    end
    idle(1);
    checks++;
    if (irq !== irq_cond(out_q.size())) begin errors++; $display("FAIL irq_rise: got %b exp %b", irq, irq_cond(out_q.size())); end
    csr_read(A_OUTCNT, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL outcount_3: got %0d exp 3", d); end
    for (int i = 0; i < 3; i++) begin
      pop_block();
      read_hold(h);
      checks++;
      if (h !== hold_m) begin errors++; $display("FAIL pop_hold[%0d]: got %h exp %h", i, h, hold_m); end
      check_status("pop");
    end
    pop_block();
    read_hold(h);
    checks++;
    if (h !== hold_m) begin errors++; $display("FAIL unf_hold_kept: got %h exp %h", h, hold_m); end
    check_status("unf_set");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b exp 0", irq); end
    csr_write(A_STATUS, 32'h20);
    unf_m = 1'b0;
    check_status("unf_clear");
  endtask

  task automatic test_full_concurrent();
    logic [DW-1:0] d;
    logic [BLKW-1:0] h, x;
    irq_en_m = 1'b0;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b0, 1'b0));
    for (int i = 0; i < DEPTH + 1; i++) drive_result({$urandom, $urandom});
    checks++;
    if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", bus.res_ready); end
    check_status("out_full");
    // Result waits while full; the pop frees a slot and the waiting result
    // is taken the cycle after res_ready returns.
    x = {$urandom, $urandom};
    bus.res_data = x; bus.res_valid = 1'b1;
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b1, 1'b0));
    idle(1);
    hold_m = out_q.pop_front(); rdv_m = 1'b1;
    checks++;
    if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b exp 1", bus.res_ready); end
    idle(1);
    bus.res_valid = 1'b0;
    out_q.push_back(x);
    csr_read(A_OUTCNT, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL outcount_refill: got %0d exp 4", d); end
    pop_block();
    // Pop and result write land on the same edge: count unchanged.
    x = {$urandom, $urandom};
    csr_write(A_CTRL, ctrl_word(1'b0, 1'b1, 1'b0));
    bus.res_data = x; bus.res_valid = 1'b1;
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    hold_m = out_q.pop_front(); rdv_m = 1'b1;
    out_q.push_back(x);
    idle(1);
    csr_read(A_OUTCNT, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL outcount_simul: got %0d exp 3", d); end
    for (int i = 0; i < 3; i++) begin
      pop_block();
      read_hold(h);
      checks++;
      if (h !== hold_m) begin errors++; $display("FAIL wrap_pop_hold[%0d]: got %h exp %h", i, h, hold_m); end
    end
    check_status("out_drained");
  endtask

  initial begin
    bus.slave_address = '0; bus.slave_writedata = '0;
    bus.slave_write = 1'b0; bus.slave_read = 1'b0; bus.slave_chipselect = 1'b0;
    bus.core_ready = 1'b0; bus.res_data = '0; bus.res_valid = 1'b0;
    test_reset();
    test_single_block();
    test_overflow_wrap();
    test_stall_flush();
    test_results_irq();
    test_full_concurrent();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
